// File: rtl/ttx_byte_framer.sv
// Teletext byte framer: hunts for the framing code after each line start, then packs LSB-first bytes for the byte FIFO.
// Optional macro TTX_PARITY_CHECK_EN adds odd-parity checking with erasure marking on bytes 2 and up.
module ttx_byte_framer #(
    parameter logic [7:0] FRAMING_CODE = 8'h27,
    parameter int         PKT_BYTES    = 42,
    parameter int         SEARCH_BITS  = 32,
    parameter int         FC_TOL       = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       line_start,
    input  logic       fifo_full,
    output logic [7:0] data_out,
    output logic       write_en,
    output logic       pkt_start,
    output logic       pkt_done,
    output logic       pkt_abort,
    output logic       overflow,
    output logic       busy,
`ifdef TTX_PARITY_CHECK_EN
    output logic       parity_err,
`endif
    output logic [1:0] dbg_state
);

    localparam int SCW = $clog2(SEARCH_BITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RECV   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       shift_reg;
    logic [3:0]       fill_cnt;
    logic [SCW-1:0]   search_cnt;
    logic [2:0]       bit_cnt;
    logic [5:0]       byte_cnt;

    logic [7:0]       next_shift;
    logic [3:0]       fill_next;
    logic             fc_match;
    logic             search_last;
    logic             byte_done;
    logic             last_byte;
    logic             abort_nxt;
    logic             par_fail;
    logic [7:0]       byte_val;

    assign next_shift  = {bit_in, shift_reg[7:1]};
    assign fill_next   = (fill_cnt == 4'd8) ? 4'd8 : fill_cnt + 4'd1;
    assign fc_match    = (fill_next == 4'd8) &&
                         ($countones(next_shift ^ FRAMING_CODE) <= FC_TOL);
    assign search_last = (search_cnt == SCW'(SEARCH_BITS - 1));
    assign byte_done   = (state == RECV) && bit_valid && (bit_cnt == 3'd7) && !line_start;
    assign last_byte   = (byte_cnt == 6'(PKT_BYTES - 1));

    // Bytes 0 and 1 carry the Hamming-coded address and are never parity checked.
`ifdef TTX_PARITY_CHECK_EN
    assign par_fail = (byte_cnt >= 6'd2) && !(^next_shift);
`else
    assign par_fail = 1'b0;
`endif
    assign byte_val = par_fail ? 8'hFF : next_shift;

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        abort_nxt = 1'b0;
        if (line_start) begin
            state_nxt = SEARCH;
            abort_nxt = (state == RECV);
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                SEARCH: begin
                    if (bit_valid) begin
                        if (fc_match)         state_nxt = RECV;
                        else if (search_last) state_nxt = IDLE;
                    end
                end
                RECV: begin
                    if (byte_done && last_byte) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_reg  <= 8'd0;
            fill_cnt   <= 4'd0;
            search_cnt <= '0;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 6'd0;
            data_out   <= 8'd0;
            write_en   <= 1'b0;
            pkt_start  <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_abort  <= 1'b0;
            overflow   <= 1'b0;
`ifdef TTX_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            write_en  <= 1'b0;
            pkt_start <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_abort <= abort_nxt;
`ifdef TTX_PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            if (line_start) begin
                shift_reg  <= 8'd0;
                fill_cnt   <= 4'd0;
                search_cnt <= '0;
                bit_cnt    <= 3'd0;
                byte_cnt   <= 6'd0;
            end else if (bit_valid) begin
                case (state)
                    SEARCH: begin
                        shift_reg  <= next_shift;
                        fill_cnt   <= fill_next;
                        search_cnt <= search_cnt + SCW'(1);
                        if (fc_match) begin
                            bit_cnt  <= 3'd0;
                            byte_cnt <= 6'd0;
                        end
                    end
                    RECV: begin
                        shift_reg <= next_shift;
                        bit_cnt   <= bit_cnt + 3'd1;
                        // A byte dropped on a full FIFO still advances the count to keep packet alignment.
                        if (bit_cnt == 3'd7) begin
                            data_out  <= byte_val;
                            write_en  <= !fifo_full;
                            pkt_start <= (byte_cnt == 6'd0);
                            pkt_done  <= last_byte;
                            byte_cnt  <= byte_cnt + 6'd1;
                            if (fifo_full) overflow <= 1'b1;
`ifdef TTX_PARITY_CHECK_EN
                            parity_err <= par_fail;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ttx_byte_framer.sv
// Bench for ttx_byte_framer: two instances (FC_TOL 0 and 1) share stimulus; written bytes are checked against expected queues.
module tb_ttx_byte_framer;

  localparam int PKT = 42;
  localparam int W   = 11;

  typedef struct {
    logic [7:0] fc;
    int         full_idx;
    bit         e0;
    bit         e1;
    int         wr0;
    int         wr1;
    logic       ovf;
  } scen_t;

  logic       clk = 1'b0;
  logic       reset, bit_in, bit_valid, line_start, fifo_full;
  logic [7:0] data0, data1;
  logic       we0, we1, ps0, ps1, pd0, pd1, pa0, pa1, ov0, ov1, busy0, busy1;
  logic [1:0] st0, st1;
  logic       perr0, perr1;

  logic [W-1:0] exp0_q[$];
  logic [W-1:0] exp1_q[$];
  int checks = 0, errors = 0;
  int wr0 = 0, wr1 = 0, ab0 = 0, ab1 = 0;
  scen_t tbl[3];

  // clock / reset
  always #5 clk = ~clk;

  ttx_byte_framer #(.FC_TOL(0)) dut0 (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .line_start(line_start), .fifo_full(fifo_full), .data_out(data0),
    .write_en(we0), .pkt_start(ps0), .pkt_done(pd0), .pkt_abort(pa0),
    .overflow(ov0), .busy(busy0),
`ifdef TTX_PARITY_CHECK_EN
    .parity_err(perr0),
`endif
    .dbg_state(st0)
  );

  ttx_byte_framer #(.FC_TOL(1)) dut1 (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .line_start(line_start), .fifo_full(fifo_full), .data_out(data1),
    .write_en(we1), .pkt_start(ps1), .pkt_done(pd1), .pkt_abort(pa1),
    .overflow(ov1), .busy(busy1),
`ifdef TTX_PARITY_CHECK_EN
    .parity_err(perr1),
`endif
    .dbg_state(st1)
  );

`ifndef TTX_PARITY_CHECK_EN
  assign perr0 = 1'b0;
  assign perr1 = 1'b0;
`endif

  function automatic logic exp_perr(int idx, logic [7:0] raw);
`ifdef TTX_PARITY_CHECK_EN
    return (idx >= 2) && !(^raw);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [7:0] exp_data(int idx, logic [7:0] raw);
    return exp_perr(idx, raw) ? 8'hFF : raw;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: compare every observed write against the head of its queue
  task automatic observe();
    logic [W-1:0] e;
    if (we0 === 1'b1) begin
      wr0++;
      if (exp0_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_write: unexpected write data=%0h, expected none", data0);
      end else begin
        e = exp0_q.pop_front();
        check("dut0_write", {21'd0, perr0, ps0, pd0, data0}, {21'd0, e});
      end
    end
    if (we1 === 1'b1) begin
      wr1++;
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1_write: unexpected write data=%0h, expected none", data1);
      end else begin
        e = exp1_q.pop_front();
        check("dut1_write", {21'd0, perr1, ps1, pd1, data1}, {21'd0, e});
      end
    end
    if (pa0 === 1'b1) ab0++;
    if (pa1 === 1'b1) ab1++;
  endtask

  // driver tasks
  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_in    = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    observe();
  endtask

  task automatic send_raw(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_byte(input int idx, input logic [7:0] raw, input bit full,
                           input bit e0, input bit e1);
    logic [W-1:0] ent;
    ent = {exp_perr(idx, raw), (idx == 0), (idx == PKT - 1), exp_data(idx, raw)};
    if (!full && e0) exp0_q.push_back(ent);
    if (!full && e1) exp1_q.push_back(ent);
    fifo_full = full;
    send_raw(raw);
    fifo_full = 1'b0;
  endtask

  task automatic pulse_line_start();
    @(negedge clk);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    observe();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      observe();
    end
  endtask

  task automatic send_header(input logic [7:0] fc);
    send_raw(8'h55);
    send_raw(8'h55);
    send_raw(fc);
  endtask

  initial begin
    int b0, b1;
    tbl[0] = '{fc: 8'h27, full_idx: -1, e0: 1'b1, e1: 1'b1, wr0: 42, wr1: 42, ovf: 1'b0};
    tbl[1] = '{fc: 8'h26, full_idx: -1, e0: 1'b0, e1: 1'b1, wr0: 0,  wr1: 42, ovf: 1'b0};
    tbl[2] = '{fc: 8'h27, full_idx: 5,  e0: 1'b1, e1: 1'b1, wr0: 41, wr1: 41, ovf: 1'b1};

    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; line_start = 1'b0; fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_dut0", {18'd0, data0, we0, ps0, pd0, pa0, ov0, busy0, st0}, 32'd0);
    check("reset_dut1", {18'd0, data1, we1, ps1, pd1, pa1, ov1, busy1, st1}, 32'd0);

    // bits outside a line window are ignored
    send_raw(8'h27);
    check("idle_ignores_bits", {30'd0, busy0, busy1}, 32'd0);

    // timeout: 32 run-in bits with no framing code
    b0 = wr0; b1 = wr1;
    pulse_line_start();
    for (int i = 0; i < 31; i++) send_bit((i % 2) == 0);
    check("timeout_busy_before", busy0, 1);
    send_bit(1'b0);
    check("timeout_busy0_after", busy0, 0);
    check("timeout_busy1_after", busy1, 0);
    check("timeout_writes", wr0 - b0 + wr1 - b1, 0);

    // abort after byte 10, then a full packet on the new line
    b0 = wr0; b1 = wr1;
    pulse_line_start();
    send_header(8'h27);
    for (int idx = 0; idx <= 10; idx++) send_byte(idx, 8'(idx), 1'b0, 1'b1, 1'b1);
    pulse_line_start();
    check("abort_pulse0", pa0, 1);
    check("abort_pulse1", pa1, 1);
    check("abort_state", st0, 1);
    send_header(8'h27);
    for (int idx = 0; idx < PKT; idx++) send_byte(idx, 8'(idx), 1'b0, 1'b1, 1'b1);
    idle(2);
    check("abort_writes0", wr0 - b0, 53);
    check("abort_writes1", wr1 - b1, 53);
    check("abort_busy", busy0, 0);

    // table-driven packet scenarios
    for (int s = 0; s < 3; s++) begin
      b0 = wr0; b1 = wr1;
      pulse_line_start();
      send_header(tbl[s].fc);
      for (int idx = 0; idx < PKT; idx++) begin
        send_byte(idx, 8'(idx), (idx == tbl[s].full_idx), tbl[s].e0, tbl[s].e1);
        if (idx == tbl[s].full_idx) begin
          check("drop_write_en", we0, 0);
          check("drop_data_out", data0, exp_data(idx, 8'(idx)));
          check("drop_overflow", ov0, 1);
        end
      end
      idle(2);
      check($sformatf("scen%0d_writes0", s), wr0 - b0, tbl[s].wr0);
      check($sformatf("scen%0d_writes1", s), wr1 - b1, tbl[s].wr1);
      check($sformatf("scen%0d_overflow", s), ov0, tbl[s].ovf);
      check($sformatf("scen%0d_busy", s), {30'd0, busy0, busy1}, 0);
      check($sformatf("scen%0d_q0_empty", s), exp0_q.size(), 0);
      check($sformatf("scen%0d_q1_empty", s), exp1_q.size(), 0);
    end
    check("abort_count0", ab0, 1);
    check("abort_count1", ab1, 1);

    // overflow clears only on reset
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("overflow_reset", {30'd0, ov0, ov1}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
